axi_led_bank: RTL
=================

Name: axi_led_bank

Overview:
AXI4-Lite slave driving LED_BANKS_p independent LED banks of LED_NBR_p LEDs each, with per-LED hardware blink at a programmable half-period per bank. Sits on the peripheral AXI-Lite interconnect and replaces the single-register LED peripheral. Up to two requests can be outstanding per channel. Unmapped accesses return SLVERR; unmapped reads return 0xDEADDEAD.

Parameters:
AXI_ADDR_BW_p, 12, AXI address width in bits; must be >= 4+$clog2(LED_BANKS_p).
LED_NBR_p, 32, LEDs per bank, 1..32.
LED_BANKS_p, 4, number of banks, 1..16.
PERIOD_BW_p, 24, width of the blink half-period register and counter, 1..32.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
i_axi_awaddr  in  AXI_ADDR_BW_p  write address
i_axi_awvalid  in  1  write address valid
o_axi_awready  out  1  write address ready
i_axi_wdata  in  32  write data
i_axi_wstrb  in  4  byte strobes
i_axi_wvalid  in  1  write data valid
o_axi_wready  out  1  write data ready
o_axi_bresp  out  2  write response
o_axi_bvalid  out  1  write response valid
i_axi_bready  in  1  write response ready
i_axi_araddr  in  AXI_ADDR_BW_p  read address
i_axi_arvalid  in  1  read address valid
o_axi_arready  out  1  read address ready
o_axi_rdata  out  32  read data
o_axi_rresp  out  2  read response
o_axi_rvalid  out  1  read valid
i_axi_rready  in  1  read ready
o_led  out  LED_BANKS_p*LED_NBR_p  LED drive; bank b occupies [b*LED_NBR_p +: LED_NBR_p]

Behaviour:
- Reset (async assert, sync release): all outputs 0; all registers 0; every blink phase = 1 (on). Readys stay 0 in the first cycle after release, then follow the FIFO-not-full flags.
- Register map, bank b base 0x10*b: +0x0 DATA, +0x4 BLINK_MASK, +0x8 HALF_PERIOD (PERIOD_BW_p bits), +0xC unmapped. Any address >= 0x10*LED_BANKS_p is unmapped. Address bits [1:0] are ignored.
- Writes honour wstrb per byte. Bits above LED_NBR_p (DATA, MASK) or PERIOD_BW_p are dropped on write and read back as 0.
- AW, W and AR each feed a 2-entry FIFO. Ready = FIFO not full. AW and W are accepted independently and in either order.
- Write commit: both AW and W FIFOs non-empty, and the B slot is empty or draining this cycle. Commit pops both FIFOs, updates the register, and loads B. bvalid is asserted the cycle after commit: OKAY 2'b00 if mapped, SLVERR 2'b10 if unmapped (no state change). Best case, bvalid is high 1 cycle after the later of the AW/W handshakes.
- Read: head of the AR FIFO is loaded into the R register when R is empty or draining. rvalid is asserted the next cycle: OKAY with the register value, or SLVERR with 0xDEADDEAD. rdata and rresp stay stable while rvalid && !rready. Back-to-back throughput is 1 per cycle.
- A read and a write commit to the same register in the same cycle: the read returns the pre-write value.
- Blink, per bank:
  - If HALF_PERIOD==0: counter held at 0, phase held 1.
  - Otherwise the counter increments each cycle. At HALF_PERIOD-1 it wraps to 0 and toggles phase.
  - Any write commit to HALF_PERIOD (any strobe) clears the counter and sets phase=1.
- o_led bank b = DATA & ~(BLINK_MASK & {LED_NBR_p{~phase_b}}), registered, 1 cycle after register or phase change.
- Reset mid-transaction: FIFOs are flushed, and no B or R response is issued for any request in flight.

Optional Feature:
AXI_LED_BANK_BLINK_EN
- Defined: blink logic and the BLINK_MASK/HALF_PERIOD registers are present, as above.
- Undefined: no counters or blink registers. +0x4 and +0x8 become unmapped (SLVERR, 0xDEADDEAD). o_led = DATA, registered.

Decomposition:
- Package axi_led_bank_pkg holds:
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10
  - UNMAPPED_RDATA=32'hDEADDEAD
  - offsets DATA_OFS=4'h0, MASK_OFS=4'h4, PERIOD_OFS=4'h8, BANK_STRIDE=16
  - enum reg_sel_e {REG_DATA, REG_MASK, REG_PERIOD, REG_NONE}
  - function decode_addr returning bank index and reg_sel_e
- One sub-module, axi_led_bank_fifo2: 2-entry FIFO, parametrised data width, with push/pop/full/empty. It is instantiated for AW, W ({wstrb,wdata}) and AR.

Test Plan:
- Write bank 1 DATA (0x10) = 0xA5A5_A5A5 with wstrb 4'b0101 after reset -> bresp 00, o_led[63:32] = 0x00A5_00A5; read 0x10 returns 0x00A5_00A5, rresp 00.
- Write bank 0 DATA = 0xFF, MASK (0x04) = 0x0F, HALF_PERIOD (0x08) = 3 -> o_led[7:0] alternates 0xFF/0xF0, changing every 3 cycles; rewrite HALF_PERIOD=3 mid-off-phase -> 0xFF the next cycle.
- Read 0x0C and 0x40 (LED_BANKS_p=4) -> rresp 10, rdata 0xDEADDEAD; write 0x40 -> bresp 10, o_led unchanged.
- Hold bready=0 and issue 3 writes with AW first and W 2 cycles later -> awready drops after 2 accepted entries (1 commit held in B); release bready -> 3 OKAY responses in order.
- 5 back-to-back reads with rready=1 -> arready high continuously, one rvalid per cycle; rready=0 -> rdata/rresp stable and arready low after 2 pending.
- Assert rst_n=0 with one write and one read pending -> all outputs 0 immediately; after release, readys are 0 for 1 cycle and no stale bvalid/rvalid appears.

Source files
------------

// File: rtl/axi_led_bank_pkg.sv
// rtl/axi_led_bank_pkg.sv - shared constants, register decode and strobe merge for axi_led_bank (blink regs gated by AXI_LED_BANK_BLINK_EN)
package axi_led_bank_pkg;

  localparam logic [1:0]  RESP_OKAY      = 2'b00;
  localparam logic [1:0]  RESP_SLVERR    = 2'b10;
  localparam logic [31:0] UNMAPPED_RDATA = 32'hDEADDEAD;

  localparam logic [3:0]  DATA_OFS    = 4'h0;
  localparam logic [3:0]  MASK_OFS    = 4'h4;
  localparam logic [3:0]  PERIOD_OFS  = 4'h8;
  localparam int          BANK_STRIDE = 16;

  typedef enum logic [1:0] {REG_DATA, REG_MASK, REG_PERIOD, REG_NONE} reg_sel_e;

  typedef struct packed {
    logic [3:0] bank;
    reg_sel_e   sel;
  } decode_t;

  // Map a byte address to bank and register; word offset bits [1:0] are ignored
  function automatic decode_t decode_addr(input logic [31:0] addr, input int banks);
    decode_t d;
    d.bank = addr[7:4];
    d.sel  = REG_NONE;
    if (addr < 32'(banks * BANK_STRIDE)) begin
      case (addr[3:0] & 4'hC)
        DATA_OFS:   d.sel = REG_DATA;
`ifdef AXI_LED_BANK_BLINK_EN
        MASK_OFS:   d.sel = REG_MASK;
        PERIOD_OFS: d.sel = REG_PERIOD;
`endif
        default:    d.sel = REG_NONE;
      endcase
    end
    return d;
  endfunction

  // Replace only the strobed bytes of the old register value
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old, input logic [31:0] wdata,
                                              input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) r[i*8 +: 8] = wdata[i*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/axi_led_bank_fifo2.sv
// rtl/axi_led_bank_fifo2.sv - two-entry request FIFO used for the AW, W and AR channels
module axi_led_bank_fifo2 #(
  parameter int W_p = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           push,
  input  logic           pop,
  input  logic [W_p-1:0] din,
  output logic [W_p-1:0] dout,
  output logic           full,
  output logic           empty
);

  logic [W_p-1:0] mem_q [2];
  logic           wr_ptr_q;
  logic           rd_ptr_q;
  logic [1:0]     count_q;
  logic           do_push;
  logic           do_pop;

  assign full    = (count_q == 2'd2);
  assign empty   = (count_q == 2'd0);
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Ring of two slots; overflowing push and underflowing pop are ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/axi_led_bank.sv
// rtl/axi_led_bank.sv - AXI4-Lite LED bank peripheral; per-LED blink present when AXI_LED_BANK_BLINK_EN is defined
module axi_led_bank
  import axi_led_bank_pkg::*;
#(
  parameter int AXI_ADDR_BW_p = 12,
  parameter int LED_NBR_p     = 32,
  parameter int LED_BANKS_p   = 4,
  parameter int PERIOD_BW_p   = 24
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [AXI_ADDR_BW_p-1:0]         i_axi_awaddr,
  input  logic                             i_axi_awvalid,
  output logic                             o_axi_awready,
  input  logic [31:0]                      i_axi_wdata,
  input  logic [3:0]                       i_axi_wstrb,
  input  logic                             i_axi_wvalid,
  output logic                             o_axi_wready,
  output logic [1:0]                       o_axi_bresp,
  output logic                             o_axi_bvalid,
  input  logic                             i_axi_bready,
  input  logic [AXI_ADDR_BW_p-1:0]         i_axi_araddr,
  input  logic                             i_axi_arvalid,
  output logic                             o_axi_arready,
  output logic [31:0]                      o_axi_rdata,
  output logic [1:0]                       o_axi_rresp,
  output logic                             o_axi_rvalid,
  input  logic                             i_axi_rready,
  output logic [LED_BANKS_p*LED_NBR_p-1:0] o_led
);

  logic                     ready_en;
  logic                     aw_full, aw_empty, w_full, w_empty, ar_full, ar_empty;
  logic [AXI_ADDR_BW_p-1:0] aw_head, ar_head;
  logic [35:0]              w_head;
  logic                     commit, ar_pop;
  decode_t                  wr_dec, rd_dec;
  logic [31:0]              rd_val;
  logic [LED_NBR_p-1:0]     data_q [LED_BANKS_p];
`ifdef AXI_LED_BANK_BLINK_EN
  logic [LED_NBR_p-1:0]     mask_q   [LED_BANKS_p];
  logic [PERIOD_BW_p-1:0]   period_q [LED_BANKS_p];
  logic [PERIOD_BW_p-1:0]   cnt_q    [LED_BANKS_p];
  logic [LED_BANKS_p-1:0]   phase_q;
`endif

  assign o_axi_awready = ready_en & ~aw_full;
  assign o_axi_wready  = ready_en & ~w_full;
  assign o_axi_arready = ready_en & ~ar_full;

  // Keep all readys low for the first cycle after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_en <= 1'b0;
    else        ready_en <= 1'b1;
  end

  axi_led_bank_fifo2 #(.W_p(AXI_ADDR_BW_p)) u_aw_fifo (
    .clk(clk), .rst_n(rst_n), .push(i_axi_awvalid & o_axi_awready), .pop(commit),
    .din(i_axi_awaddr), .dout(aw_head), .full(aw_full), .empty(aw_empty)
  );

  axi_led_bank_fifo2 #(.W_p(36)) u_w_fifo (
    .clk(clk), .rst_n(rst_n), .push(i_axi_wvalid & o_axi_wready), .pop(commit),
    .din({i_axi_wstrb, i_axi_wdata}), .dout(w_head), .full(w_full), .empty(w_empty)
  );

  axi_led_bank_fifo2 #(.W_p(AXI_ADDR_BW_p)) u_ar_fifo (
    .clk(clk), .rst_n(rst_n), .push(i_axi_arvalid & o_axi_arready), .pop(ar_pop),
    .din(i_axi_araddr), .dout(ar_head), .full(ar_full), .empty(ar_empty)
  );

  assign commit = ~aw_empty & ~w_empty & (~o_axi_bvalid | i_axi_bready);
  assign ar_pop = ~ar_empty & (~o_axi_rvalid | i_axi_rready);
  assign wr_dec = decode_addr(32'(aw_head), LED_BANKS_p);
  assign rd_dec = decode_addr(32'(ar_head), LED_BANKS_p);

  // Write response slot, loaded on commit and held until bready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_axi_bvalid <= 1'b0;
      o_axi_bresp  <= RESP_OKAY;
    end else if (commit) begin
      o_axi_bvalid <= 1'b1;
      o_axi_bresp  <= (wr_dec.sel == REG_NONE) ? RESP_SLVERR : RESP_OKAY;
    end else if (i_axi_bready) begin
      o_axi_bvalid <= 1'b0;
    end
  end

  // Select the addressed register for the read at the AR FIFO head
  always_comb begin
    rd_val = UNMAPPED_RDATA;
    for (int b = 0; b < LED_BANKS_p; b++) begin
      if (rd_dec.bank == 4'(b)) begin
        case (rd_dec.sel)
          REG_DATA:   rd_val = 32'(data_q[b]);
`ifdef AXI_LED_BANK_BLINK_EN
          REG_MASK:   rd_val = 32'(mask_q[b]);
          REG_PERIOD: rd_val = 32'(period_q[b]);
`endif
          default:    rd_val = UNMAPPED_RDATA;
        endcase
      end
    end
  end

  // Read response slot; data captured before any same-cycle write lands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_axi_rvalid <= 1'b0;
      o_axi_rdata  <= '0;
      o_axi_rresp  <= RESP_OKAY;
    end else if (ar_pop) begin
      o_axi_rvalid <= 1'b1;
      o_axi_rdata  <= rd_val;
      o_axi_rresp  <= (rd_dec.sel == REG_NONE) ? RESP_SLVERR : RESP_OKAY;
    end else if (i_axi_rready) begin
      o_axi_rvalid <= 1'b0;
    end
  end

  // Apply committed writes to the per-bank registers, truncating to register width
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < LED_BANKS_p; b++) begin
        data_q[b] <= '0;
`ifdef AXI_LED_BANK_BLINK_EN
        mask_q[b]   <= '0;
        period_q[b] <= '0;
`endif
      end
    end else if (commit) begin
      for (int b = 0; b < LED_BANKS_p; b++) begin
        if (wr_dec.bank == 4'(b)) begin
          case (wr_dec.sel)
            REG_DATA:   data_q[b]   <= LED_NBR_p'(apply_wstrb(32'(data_q[b]), w_head[31:0], w_head[35:32]));
`ifdef AXI_LED_BANK_BLINK_EN
            REG_MASK:   mask_q[b]   <= LED_NBR_p'(apply_wstrb(32'(mask_q[b]), w_head[31:0], w_head[35:32]));
            REG_PERIOD: period_q[b] <= PERIOD_BW_p'(apply_wstrb(32'(period_q[b]), w_head[31:0], w_head[35:32]));
`endif
            default: ;
          endcase
        end
      end
    end
  end

`ifdef AXI_LED_BANK_BLINK_EN
  // Per-bank half-period counter; a HALF_PERIOD write restarts the on phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < LED_BANKS_p; b++) begin
        cnt_q[b]   <= '0;
        phase_q[b] <= 1'b1;
      end
    end else begin
      for (int b = 0; b < LED_BANKS_p; b++) begin
        if (commit && wr_dec.sel == REG_PERIOD && wr_dec.bank == 4'(b)) begin
          cnt_q[b]   <= '0;
          phase_q[b] <= 1'b1;
        end else if (period_q[b] == '0) begin
          cnt_q[b]   <= '0;
          phase_q[b] <= 1'b1;
        end else if (cnt_q[b] == period_q[b] - PERIOD_BW_p'(1)) begin
          cnt_q[b]   <= '0;
          phase_q[b] <= ~phase_q[b];
        end else begin
          cnt_q[b] <= cnt_q[b] + PERIOD_BW_p'(1);
        end
      end
    end
  end
`endif

  // Registered LED drive; masked LEDs go dark during the off phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_led <= '0;
    end else begin
      for (int b = 0; b < LED_BANKS_p; b++) begin
`ifdef AXI_LED_BANK_BLINK_EN
        o_led[b*LED_NBR_p +: LED_NBR_p] <= data_q[b] & ~(mask_q[b] & {LED_NBR_p{~phase_q[b]}});
`else
        o_led[b*LED_NBR_p +: LED_NBR_p] <= data_q[b];
`endif
      end
    end
  end

endmodule
